// File: rtl/pmem_burst_adaptor_pkg.sv
// Shared widths and FSM state type for the cacheline-to-burst memory adaptor.
// A cacheline is moved as BEATS consecutive BURST_W-bit memory beats.
package pmem_burst_adaptor_pkg;

   localparam int LINE_W   = 256;
   localparam int BURST_W  = 64;
   localparam int BEATS    = LINE_W / BURST_W;
   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = $clog2(LINE_W / 8);
   localparam int CNT_W    = $clog2(BEATS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } pmem_burst_state_t;

   // Clear the byte-offset bits so bursts always start on a line boundary.
   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] mask;
      mask = {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
      return addr & mask;
   endfunction

endpackage

// File: rtl/pmem_burst_adaptor_if.sv
// Cache-side line request/response and memory-side burst signals.
// slave = the adaptor's view; master = the cache plus memory surrounding it.
interface pmem_burst_adaptor_if;
   import pmem_burst_adaptor_pkg::*;

   logic                pmem_read;
   logic                pmem_write;
   logic [ADDR_W-1:0]   pmem_address;
   logic [LINE_W-1:0]   pmem_wdata;
   logic [LINE_W-1:0]   pmem_rdata;
   logic                pmem_resp;

   logic                mem_read;
   logic                mem_write;
   logic [ADDR_W-1:0]   mem_address;
   logic [BURST_W-1:0]  mem_wdata;
   logic [BURST_W-1:0]  mem_rdata;
   logic                mem_resp;

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  mem_rdata, mem_resp,
      output pmem_rdata, pmem_resp,
      output mem_read, mem_write, mem_address, mem_wdata
   );

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      output mem_rdata, mem_resp,
      input  pmem_rdata, pmem_resp,
      input  mem_read, mem_write, mem_address, mem_wdata
   );

endinterface

// File: rtl/pmem_burst_adaptor.sv
// Turns a whole-cacheline read/write request into a BEATS-long memory burst
// and answers the cache with a single-cycle pmem_resp.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for pmem_write / pmem_read (write wins)
//   S_READ  | mem_read high; each mem_resp stores one beat into the line
//   S_WRITE | mem_write high; each mem_resp retires one latched beat
//   S_RESP  | pmem_resp high for one cycle, then back to S_IDLE
module pmem_burst_adaptor
   import pmem_burst_adaptor_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   pmem_burst_adaptor_if.slave   bus
);

   pmem_burst_state_t   state_q;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;
   logic                beat_last;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wdata_q;
   logic [LINE_W-1:0]   rdata_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic                pmem_resp_q;

   // Wraps to zero naturally on the last beat, ready for the next request.
   assign count_d   = count_q + 1'b1;
   assign beat_last = (count_q == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         pmem_resp_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.pmem_write) begin
                  addr_q      <= line_align(bus.pmem_address);
                  wdata_q     <= bus.pmem_wdata;
                  count_q     <= '0;
                  mem_write_q <= 1'b1;
                  state_q     <= S_WRITE;
               end else if (bus.pmem_read) begin
                  addr_q      <= line_align(bus.pmem_address);
                  count_q     <= '0;
                  mem_read_q  <= 1'b1;
                  state_q     <= S_READ;
               end
            end

            S_READ: begin
               if (bus.mem_resp) begin
                  rdata_q[count_q*BURST_W +: BURST_W] <= bus.mem_rdata;
                  count_q <= count_d;
                  if (beat_last) begin
                     mem_read_q  <= 1'b0;
                     pmem_resp_q <= 1'b1;
                     state_q     <= S_RESP;
                  end
               end
            end

            S_WRITE: begin
               if (bus.mem_resp) begin
                  count_q <= count_d;
                  if (beat_last) begin
                     mem_write_q <= 1'b0;
                     pmem_resp_q <= 1'b1;
                     state_q     <= S_RESP;
                  end
               end
            end

            S_RESP: begin
               pmem_resp_q <= 1'b0;
               state_q     <= S_IDLE;
            end

            default: begin
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               pmem_resp_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_read    = mem_read_q;
   assign bus.mem_write   = mem_write_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_wdata   = wdata_q[count_q*BURST_W +: BURST_W];
   assign bus.pmem_rdata  = rdata_q;
   assign bus.pmem_resp   = pmem_resp_q;

endmodule
